// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: header {len,addr}, payload bytes popped from a
// first-word-fall-through buffer, then an XOR parity byte. busy from the router stalls
// the byte currently on data_in.
// Optional build macro: ROUTER_PKT_TX_ERR_INJ_EN adds inject_err to corrupt the parity byte.
module router_pkt_tx #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned MAX_LEN    = 63
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] addr,
    input  logic [5:0] len,
    input  logic [7:0] pl_data,
    input  logic       busy,
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
    input  logic       inject_err,
`endif
    output logic       ready,
    output logic       pl_rd,
    output logic       pkt_valid,
    output logic [7:0] data_in,
    output logic       done,
    output logic       req_err
);

    // IDLE itself supplies the first forced idle cycle: a start sampled in IDLE only
    // drives the header one edge later, so GAP has to cover the remaining cycles.
    localparam logic [3:0] GapLoad = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic [6:0] MaxLen  = 7'(MAX_LEN);

    typedef enum logic [2:0] {StIdle, StHdr, StPld, StPar, StGap} state_e;

    state_e     state_q, state_d;
    logic [5:0] len_q, len_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] parity_q, parity_d;
    logic [7:0] data_q, data_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       done_q, done_d;
    logic       req_err_q, req_err_d;
    logic [3:0] gap_q, gap_d;
    logic       rd;
    logic       legal;
    logic [7:0] par_out;

`ifdef ROUTER_PKT_TX_ERR_INJ_EN
    logic inj_q, inj_d;
    assign par_out = inj_q ? ~parity_q : parity_q;
`else
    assign par_out = parity_q;
`endif

    assign ready     = (state_q == StIdle) && (gap_q == 4'd0);
    assign legal     = (addr != 2'd3) && (len != 6'd0) && ({1'b0, len} <= MaxLen);
    // A packet being flushed by reset must not pop a byte it will never send.
    assign pl_rd     = rd && !reset;
    assign pkt_valid = pkt_valid_q;
    assign data_in   = data_q;
    assign done      = done_q;
    assign req_err   = req_err_q;

    // Next-state, datapath updates and the payload pop strobe.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        parity_d    = parity_q;
        data_d      = data_q;
        pkt_valid_d = pkt_valid_q;
        done_d      = 1'b0;
        req_err_d   = 1'b0;
        gap_d       = gap_q;
        rd          = 1'b0;
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
        inj_d       = inj_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start && ready) begin
                    if (legal) begin
                        state_d     = StHdr;
                        len_d       = len;
                        cnt_d       = 6'd0;
                        data_d      = {len, addr};
                        parity_d    = {len, addr};
                        pkt_valid_d = 1'b1;
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
                        inj_d       = inject_err;
`endif
                    end else begin
                        req_err_d = 1'b1;
                    end
                end
            end
            StHdr: begin
                if (!busy) begin
                    rd       = 1'b1;
                    data_d   = pl_data;
                    parity_d = parity_q ^ pl_data;
                    cnt_d    = 6'd1;
                    state_d  = StPld;
                end
            end
            StPld: begin
                if (!busy) begin
                    if (cnt_q < len_q) begin
                        rd       = 1'b1;
                        data_d   = pl_data;
                        parity_d = parity_q ^ pl_data;
                        cnt_d    = cnt_q + 6'd1;
                    end else begin
                        data_d      = par_out;
                        pkt_valid_d = 1'b0;
                        state_d     = StPar;
                    end
                end
            end
            StPar: begin
                if (!busy) begin
                    done_d  = 1'b1;
                    data_d  = 8'h00;
                    gap_d   = GapLoad;
                    state_d = (GapLoad == 4'd0) ? StIdle : StGap;
                end
            end
            StGap: begin
                gap_d = gap_q - 4'd1;
                if (gap_q <= 4'd1) begin
                    gap_d   = 4'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            len_q       <= 6'd0;
            cnt_q       <= 6'd0;
            parity_q    <= 8'h00;
            data_q      <= 8'h00;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            req_err_q   <= 1'b0;
            gap_q       <= 4'd0;
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
            inj_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            parity_q    <= parity_d;
            data_q      <= data_d;
            pkt_valid_q <= pkt_valid_d;
            done_q      <= done_d;
            req_err_q   <= req_err_d;
            gap_q       <= gap_d;
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
            inj_q       <= inj_d;
`endif
        end
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source for the router input port: frames one packet per request as header, payload and parity bytes on pkt_valid/data_in. The router receiver consumes these bytes and returns busy to stall the source. Used as a traffic generator in front of the router top and as the host-side transmitter in system builds. Payload bytes come from a first-word-fall-through buffer through a pl_rd strobe.

Parameters:
GAP_CYCLES, 1, idle cycles forced in IDLE after a packet completes before start is accepted again (0..15)
MAX_LEN, 63, largest accepted payload length; must be at most 63 (6-bit length field)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to send one packet; sampled only when ready=1
addr  input  2  destination port 0..2; 3 is illegal
len  input  6  payload byte count, 1..MAX_LEN
pl_data  input  8  payload byte at head of source buffer, valid whenever pl_rd is asserted
busy  input  1  router stall; while high the current byte is held
ready  output  1  high in IDLE once the gap has expired
pl_rd  output  1  one-cycle pop of the payload source, combinational from state and busy
pkt_valid  output  1  router packet-valid, registered
data_in  output  8  router data byte, registered
done  output  1  one-cycle pulse after the parity byte is accepted
req_err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset state: state=IDLE; pkt_valid=0, data_in=8'h00, done=0, req_err=0, pl_rd=0, parity register=0, gap counter=0. Reset applied mid-packet aborts the packet immediately with no parity byte.
- States: IDLE, HDR, PLD, PAR, GAP.
- IDLE:
  - ready = (gap counter == 0).
  - start & ready & addr!=3 & len!=0 & len<=MAX_LEN -> HDR. Same edge: latch len and addr; data_in <= {len,addr}; pkt_valid <= 1; parity <= {len,addr}.
  - start & ready with an illegal addr or len: stay in IDLE, req_err pulses for 1 cycle, and outputs do not change.
- Byte acceptance: a byte on data_in is accepted on any rising edge where busy=0. If busy=1, data_in, pkt_valid, the state and the byte counter all hold, and pl_rd=0.
- HDR:
  - On acceptance, pl_rd=1 in that same cycle; data_in <= pl_data; parity <= parity ^ pl_data; byte counter <= 1; go to PLD.
- PLD:
  - On acceptance with counter < len: pl_rd=1, load the next byte, update parity, increment the counter.
  - On acceptance with counter == len: data_in <= parity (final XOR value); pkt_valid <= 0; go to PAR.
- PAR:
  - The parity byte is presented with pkt_valid=0 and must also see busy=0 to be accepted.
  - On acceptance: done pulses on the next cycle; data_in <= 0; gap counter <= GAP_CYCLES; go to GAP, or straight to IDLE when GAP_CYCLES=0.
- GAP: decrement the gap counter each cycle; go to IDLE when it reaches 1. No start is sampled in GAP.
- Latency: start to header byte on data_in is 1 cycle. With busy held low, a packet occupies len+2 cycles on the interface, and the next header can appear at the earliest GAP_CYCLES+1 cycles after the parity cycle.
- Parity: 8-bit XOR of the header and all payload bytes; this matches the router's internal parity check.
- busy during PAR: the parity byte is held; done is not issued until it is accepted.
- start asserted while ready=0: ignored, with no req_err.

Optional Feature:
Macro ROUTER_PKT_TX_ERR_INJ_EN.
- Defined: adds input inject_err (1 bit), sampled together with an accepted start. When it was 1, the transmitted parity byte is ~parity, so the router flags err.
- Undefined: the port is absent and parity is always correct.

Test Plan:
1. Single packet, busy=0: start with addr=2, len=1, pl_data=8'h5A -> data_in sequence 8'h06 (pkt_valid=1), 8'h5A (pkt_valid=1), 8'h5C (pkt_valid=0); exactly one pl_rd pulse; done pulses 1 cycle after the parity cycle.
2. Stall: addr=1, len=3, payload 8'h11/8'h22/8'h33, busy high for 2 cycles during the second payload byte -> 8'h22 held for 3 cycles; header 8'h0D; parity 8'h0D^8'h11^8'h22^8'h33 = 8'h0D; total 3 pl_rd pulses.
3. Illegal requests: addr=3 with len=4, then addr=0 with len=0 -> req_err pulses once for each; pkt_valid stays 0; pl_rd never asserts.
4. Back-to-back with GAP_CYCLES=1: start held high continuously -> exactly 1 idle cycle between parity and the next header; ready is low in HDR/PLD/PAR/GAP.
5. Reset mid-payload: addr=0, len=10, reset asserted after 4 payload bytes -> on the next edge pkt_valid=0, data_in=0, state IDLE; a following packet with addr=0, len=1, payload 8'hFF produces header 8'h04 and parity 8'hFB.
6. With ROUTER_PKT_TX_ERR_INJ_EN defined and inject_err=1 on the test 1 packet -> parity byte is 8'hA3; done still pulses.
